// File: rtl/image_mem_arbiter.sv
// Arbitrates the single-port image RAM between a writer and a reader (round-robin on ties)
// and runs a clear sweep that fills every address with clr_value.
module image_mem_arbiter #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [RAM_ADDR_BITS-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0]     wr_data,
  output logic                     wr_ack,
  input  logic                     rd_req,
  input  logic [RAM_ADDR_BITS-1:0] rd_addr,
  output logic                     rd_ack,
  output logic [RAM_WIDTH-1:0]     rd_data,
  output logic                     rd_valid,
  input  logic                     clr_start,
  input  logic [RAM_WIDTH-1:0]     clr_value,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_di,
  input  logic [RAM_WIDTH-1:0]     mem_do
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                   state, state_next;
  logic [RAM_ADDR_BITS-1:0] cnt;
  logic                     last_wr;  // 1: write was granted last, 0: read

  always_comb begin
    state_next = state;
    wr_ack     = 1'b0;
    rd_ack     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = rd_addr;
    mem_di     = wr_data;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_next = CLEAR;
        end else if (wr_req && (!rd_req || !last_wr)) begin
          wr_ack   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = wr_addr;
        end else if (rd_req) begin
          rd_ack = 1'b1;
        end
      end
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = cnt;
        mem_di   = clr_value;
        // Terminate on the all-ones address so the counter never needs an extra bit.
        if (cnt == {RAM_ADDR_BITS{1'b1}}) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_wr  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_next;
      rd_valid <= rd_ack;
      clr_busy <= (state_next == CLEAR);
      clr_done <= (state == CLEAR) && (state_next == IDLE);
      if (rd_ack) rd_data <= mem_do;
      if (wr_ack || rd_ack) last_wr <= wr_ack;
      if (state == IDLE && clr_start) cnt <= '0;
      else if (state == CLEAR)        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed bench for image_mem_arbiter with a behavioural RAM (sync write, async read).
module tb_image_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req, rd_req, clr_start;
  logic [9:0] wr_addr, rd_addr, mem_addr;
  logic [7:0] wr_data, clr_value, rd_data, mem_di, mem_do;
  logic       wr_ack, rd_ack, rd_valid, clr_busy, clr_done, mem_we;
  logic [7:0] ram [0:1023];

  int n_cmp = 0;
  int n_err = 0;
  int busy_n, done_n, acks_n;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_di;
  assign mem_do = ram[mem_addr];

  image_mem_arbiter #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] d, input string tag);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    #1;
    chk({tag, "_wr_ack"}, wr_ack, 1'b1);
    tick();
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a, input logic [7:0] exp, input string tag);
    rd_req = 1'b1; rd_addr = a;
    #1;
    chk({tag, "_rd_ack"}, rd_ack, 1'b1);
    tick();
    rd_req = 1'b0;
    chk({tag, "_rd_valid"}, rd_valid, 1'b1);
    chk({tag, "_rd_data"}, rd_data, exp);
  endtask

  // Starts a sweep and samples once per cycle until clr_busy drops (bounded).
  task automatic run_sweep(input logic [7:0] val, input int repulse_at, input int abort_at,
                           output int busy, output int done, output int acks);
    busy = 0; done = 0; acks = 0;
    clr_start = 1'b1; clr_value = val;
    #1;
    chk("clr_start_no_ack", {30'd0, wr_ack, rd_ack}, 32'd0);
    tick();
    clr_start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (clr_done) done++;
      if (!clr_busy) break;
      busy++;
      if (wr_ack || rd_ack) acks++;
      clr_start = (busy == repulse_at);
      if (busy == abort_at) begin
        rst = 1'b1;
        break;
      end
      tick();
    end
    clr_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; clr_start = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; clr_value = '0;
    #2;
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_clr_busy", clr_busy, 1'b0);
    chk("rst_clr_done", clr_done, 1'b0);
    chk("rst_comb", {29'd0, wr_ack, rd_ack, mem_we}, 32'd0);
    tick();
    rst = 1'b0;

    // Single write then read
    do_write(10'h005, 8'hA5, "wr005");
    do_read(10'h005, 8'hA5, "rd005");
    tick();
    chk("idle_rd_valid_low", rd_valid, 1'b0);
    chk("idle_rd_data_hold", rd_data, 8'hA5);

    // Round-robin tie after a fresh reset: W,R,W,R
    rst = 1'b1; #1; tick(); rst = 1'b0;
    wr_req = 1'b1; wr_addr = 10'h200; wr_data = 8'h77;
    rd_req = 1'b1; rd_addr = 10'h005;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_wr_ack", i), wr_ack, (i % 2) == 0);
      chk($sformatf("rr%0d_rd_ack", i), rd_ack, (i % 2) == 1);
      tick();
      chk($sformatf("rr%0d_rd_valid", i), rd_valid, (i % 2) == 1);
    end
    chk("rr_rd_data", rd_data, 8'hA5);

    // Full clear with both requests pending
    rd_addr = 10'h000;
    run_sweep(8'h3C, -1, -1, busy_n, done_n, acks_n);
    chk("clr1_busy_cycles", busy_n, 1024);
    chk("clr1_acks", acks_n, 0);
    chk("clr1_done_now", clr_done, 1'b1);
    chk("clr1_pending_wr", wr_ack, 1'b1);
    tick();
    chk("clr1_done_pulse", clr_done, 1'b0);
    chk("clr1_pending_rd", rd_ack, 1'b1);
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    chk("clr1_rd000", rd_data, 8'h3C);
    do_read(10'h1FF, 8'h3C, "clr1_1ff");
    do_read(10'h3FF, 8'h3C, "clr1_3ff");
    do_read(10'h200, 8'h77, "post_clr_wr");

    // clr_start re-pulsed mid-sweep must not extend it
    run_sweep(8'h5A, 500, -1, busy_n, done_n, acks_n);
    chk("clr2_busy_cycles", busy_n, 1024);
    tick(); tick();
    chk("clr2_still_idle", clr_busy, 1'b0);
    chk("clr2_done_count", done_n, 1);

    // Reset with addresses 0x000..0x063 written
    run_sweep(8'h3C, -1, 101, busy_n, done_n, acks_n);
    #1;
    chk("abort_clr_busy", clr_busy, 1'b0);
    chk("abort_rd_data", rd_data, 8'h00);
    chk("abort_rd_valid", rd_valid, 1'b0);
    chk("abort_mem_we", mem_we, 1'b0);
    tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (clr_done) done_n++;
      tick();
    end
    chk("abort_no_done", done_n, 0);
    do_read(10'h000, 8'h3C, "abort_000");
    do_read(10'h063, 8'h3C, "abort_063");
    do_read(10'h064, 8'h5A, "abort_064");

    // Address wrap / no aliasing
    do_write(10'h3FF, 8'h11, "wrap_wr3ff");
    do_write(10'h000, 8'h22, "wrap_wr000");
    do_read(10'h3FF, 8'h11, "wrap_rd3ff");
    do_read(10'h000, 8'h22, "wrap_rd000");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
